spi_byte_sequencer: RTL and testbench

- Host-side controller that feeds the SPI byte shifter and drains it.
- Accepts TX bytes from the host over a valid/ready stream and buffers them in a small FIFO.
- For each byte it drives the shifter's load and unload strobes with exact cycle timing, then captures the received byte into an RX FIFO that the host reads over a second valid/ready stream.
- Sits between the SoC bus glue (upstream) and the SPI shifter (downstream).

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_byte_sequencer_fifo.sv | 51 +++++
 rtl/spi_byte_sequencer.sv | 140 ++++++++++++++
 tb/tb_spi_byte_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte sequencer slice.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W     = 8;
  localparam int unsigned SPI_BIT_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    UNLOAD,
    CAPTURE
  } spi_state_e;

endpackage

// File: rtl/spi_byte_sequencer_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock_in,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_level;
  logic             w_push;
  logic             w_pop;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign o_level = w_level;
  assign o_full  = (w_level == PW'(DEPTH));
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Guard locally so a stray request can never corrupt the pointers.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock_in) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds the SPI byte shifter from a TX FIFO and drains its result into an RX FIFO,
// driving the load/unload strobes with fixed 11-cycle framing per byte.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BIT_CYCLES = SPI_BIT_CYCLES
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic [SPI_BYTE_W-1:0]         i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic [SPI_BYTE_W-1:0]         o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic                          o_spi_load,
  output logic                          o_spi_unload,
  output logic [SPI_BYTE_W-1:0]         o_spi_datain,
  input  logic [SPI_BYTE_W-1:0]         i_spi_dataout,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(BIT_CYCLES + 1);

  spi_state_e              r_state;
  logic                    r_load;
  logic                    r_unload;
  logic                    r_busy;
  logic [SPI_BYTE_W-1:0]   r_datain;
  logic [CNT_W-1:0]        r_cnt;

  logic [SPI_BYTE_W-1:0]   w_tx_head;
  logic                    w_tx_full;
  logic                    w_tx_empty;
  logic                    w_rx_full;
  logic                    w_rx_empty;
  logic [LVL_W-1:0]        w_tx_level;
  logic [LVL_W-1:0]        w_rx_level;
  logic                    w_tx_push;
  logic                    w_rx_pop;
  logic                    w_start;

  assign w_tx_push    = i_tx_valid & ~w_tx_full;
  assign w_rx_pop     = i_rx_ready & ~w_rx_empty;
  assign o_tx_ready   = ~w_tx_full;
  assign o_rx_valid   = ~w_rx_empty;
  assign o_tx_level   = w_tx_level;
  assign o_rx_level   = w_rx_level;
  assign o_spi_load   = r_load;
  assign o_spi_unload = r_unload;
  assign o_spi_datain = r_datain;
  assign o_busy       = r_busy;

  // Start only with RX room for the result; a byte landing in CAPTURE counts as in flight.
  assign w_start = ~w_tx_empty & ~w_rx_full &
                   (({1'b0, w_rx_level} + (LVL_W+1)'(r_state == CAPTURE)) <
                    (LVL_W+1)'(FIFO_DEPTH));

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock_in (clock_in),
    .reset    (reset),
    .i_push   (w_tx_push),
    .i_wdata  (i_tx_data),
    .i_pop    (r_state == LOAD),
    .o_rdata  (w_tx_head),
    .o_full   (w_tx_full),
    .o_empty  (w_tx_empty),
    .o_level  (w_tx_level)
  );

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock_in (clock_in),
    .reset    (reset),
    .i_push   (r_state == CAPTURE),
    .i_wdata  (i_spi_dataout),
    .i_pop    (w_rx_pop),
    .o_rdata  (o_rx_data),
    .o_full   (w_rx_full),
    .o_empty  (w_rx_empty),
    .o_level  (w_rx_level)
  );

  // Strobes are set on the transition into their state so each is high for exactly that state.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_load   <= 1'b0;
      r_unload <= 1'b0;
      r_busy   <= 1'b0;
      r_datain <= '0;
      r_cnt    <= '0;
    end else begin
      r_load   <= 1'b0;
      r_unload <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= LOAD;
            r_load   <= 1'b1;
            r_busy   <= 1'b1;
            r_datain <= w_tx_head;
          end
        end
        LOAD: begin
          r_state <= SHIFT;
          r_cnt   <= '0;
        end
        SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIT_CYCLES - 1)) begin
            r_state  <= UNLOAD;
            r_unload <= 1'b1;
          end
        end
        UNLOAD: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (w_start) begin
            r_state  <= LOAD;
            r_load   <= 1'b1;
            r_datain <= w_tx_head;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a loopback shifter model (XOR key) and strobe monitor.
module tb_spi_byte_sequencer;

  logic       clock_in = 1'b0;
  logic       reset;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic       o_spi_load;
  logic       o_spi_unload;
  logic [7:0] o_spi_datain;
  logic [7:0] i_spi_dataout;
  logic       o_busy;
  logic [2:0] o_tx_level;
  logic [2:0] o_rx_level;

  spi_byte_sequencer #(.FIFO_DEPTH(4), .BIT_CYCLES(8)) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .i_rx_ready    (i_rx_ready),
    .o_spi_load    (o_spi_load),
    .o_spi_unload  (o_spi_unload),
    .o_spi_datain  (o_spi_datain),
    .i_spi_dataout (i_spi_dataout),
    .o_busy        (o_busy),
    .o_tx_level    (o_tx_level),
    .o_rx_level    (o_rx_level)
  );

  always #5 clock_in = ~clock_in;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shifter model: latch on load, present (byte ^ key) after unload.
  logic [7:0] key = 8'h00;
  logic [7:0] sh_reg;
  logic [7:0] sh_out = 8'h00;
  always @(posedge clock_in) begin
    if (o_spi_load)   sh_reg <= o_spi_datain;
    if (o_spi_unload) sh_out <= sh_reg ^ key;
  end
  assign i_spi_dataout = sh_out;

  int cyc = 0;
  always @(posedge clock_in) cyc++;

  int last_load = 0;
  int n_loads   = 0;
  int n_unloads = 0;
  int load_q[$];
  logic saw_full = 1'b0;

  always @(negedge clock_in) begin
    if (!reset) begin
      if (o_spi_load || o_spi_unload)
        chk("strobe_excl", 32'(o_spi_load & o_spi_unload), 0);
      if (o_spi_load) begin
        last_load = cyc;
        n_loads++;
        load_q.push_back(cyc);
      end
      if (o_spi_unload) begin
        chk("load_to_unload", 32'(cyc - last_load), 9);
        n_unloads++;
      end
      if (o_tx_level == 3'd4) begin
        saw_full = 1'b1;
        chk("tx_ready_when_full", 32'(o_tx_ready), 0);
      end
    end
  end

  // Leaves tx_valid asserted so consecutive calls hit consecutive edges.
  task automatic push(input logic [7:0] b);
    i_tx_data  = b;
    i_tx_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (o_tx_ready) begin
        @(negedge clock_in);
        return;
      end
      @(negedge clock_in);
    end
    chk("push_timeout", 32'(o_tx_ready), 1);
  endtask

  task automatic pop(input logic [7:0] exp, input string tag);
    for (int k = 0; k < 100 && !o_rx_valid; k++) @(negedge clock_in);
    if (!o_rx_valid) begin
      chk("pop_timeout", 32'(o_rx_valid), 1);
      return;
    end
    chk(tag, 32'(o_rx_data), 32'(exp));
    i_rx_ready = 1'b1;
    @(negedge clock_in);
    i_rx_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_load;
    int n_unl0;
    logic [7:0] exp_q[$];

    reset      = 1'b1;
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    i_rx_ready = 1'b0;
    repeat (3) @(negedge clock_in);

    // Reset values
    chk("rst_tx_ready", 32'(o_tx_ready), 1);
    chk("rst_rx_valid", 32'(o_rx_valid), 0);
    chk("rst_load",     32'(o_spi_load), 0);
    chk("rst_unload",   32'(o_spi_unload), 0);
    chk("rst_datain",   32'(o_spi_datain), 0);
    chk("rst_busy",     32'(o_busy), 0);
    chk("rst_tx_level", 32'(o_tx_level), 0);
    chk("rst_rx_level", 32'(o_rx_level), 0);
    reset = 1'b0;
    @(negedge clock_in);

    // Single byte: A5 out, 3C back (A5 ^ 99)
    key = 8'h99;
    push(8'hA5);
    i_tx_valid = 1'b0;
    for (int k = 0; k < 20 && !o_spi_load; k++) @(negedge clock_in);
    chk("single_load_seen", 32'(o_spi_load), 1);
    t_load = cyc;
    chk("single_datain", 32'(o_spi_datain), 'hA5);
    @(negedge clock_in);
    chk("single_load_width", 32'(o_spi_load), 0);
    for (int k = 0; k < 30 && !o_rx_valid; k++) @(negedge clock_in);
    chk("single_latency", 32'(cyc - t_load), 11);
    chk("single_rx_data", 32'(o_rx_data), 'h3C);
    chk("single_rx_level", 32'(o_rx_level), 1);
    chk("single_busy_after", 32'(o_busy), 0);
    pop(8'h3C, "single_pop");
    chk("single_rx_empty", 32'(o_rx_valid), 0);

    // Back-to-back: four bytes, loads 11 cycles apart, order preserved
    key = 8'h00;
    load_q.delete();
    for (int i = 1; i <= 4; i++) push(8'(i));
    i_tx_valid = 1'b0;
    for (int k = 0; k < 80 && !(o_rx_level == 3'd4 && !o_busy); k++) @(negedge clock_in);
    chk("b2b_loads", 32'(load_q.size()), 4);
    for (int i = 1; i < 4 && i < load_q.size(); i++)
      chk("b2b_spacing", 32'(load_q[i] - load_q[i-1]), 11);
    for (int i = 1; i <= 4; i++) pop(8'(i), "b2b_rx_order");

    // RX backpressure: six bytes with the host stalled
    key = 8'h5A;
    load_q.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    i_tx_valid = 1'b0;
    for (int k = 0; k < 100 && !(o_rx_level == 3'd4 && !o_busy); k++) @(negedge clock_in);
    repeat (20) @(negedge clock_in);
    chk("bp_busy", 32'(o_busy), 0);
    chk("bp_rx_level", 32'(o_rx_level), 4);
    chk("bp_tx_level", 32'(o_tx_level), 2);
    chk("bp_loads", 32'(load_q.size()), 4);
    chk("bp_saw_tx_full", 32'(saw_full), 1);
    for (int i = 0; i < 6; i++) pop(8'(8'h10 + i) ^ 8'h5A, "bp_rx_data");
    chk("bp_loads_total", 32'(load_q.size()), 6);

    // Push in the same cycle LOAD pops, then stream 3*DEPTH bytes through both FIFOs
    key = 8'h33;
    push(8'h40);
    push(8'h41);
    push(8'h42);
    chk("simul_tx_level", 32'(o_tx_level), 2);
    fork
      begin
        for (int i = 3; i < 12; i++) push(8'(8'h40 + i));
        i_tx_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 12; j++) pop(8'(8'h40 + j) ^ 8'h33, "wrap_rx_data");
      end
    join

    // Random traffic with a scoreboard
    key = 8'hC3;
    for (int c = 0; c < 2000; c++) begin
      i_tx_valid = 1'($urandom_range(0, 1));
      i_tx_data  = 8'($urandom);
      i_rx_ready = ($urandom_range(0, 3) != 0);
      if (i_tx_valid && o_tx_ready) exp_q.push_back(i_tx_data ^ key);
      if (i_rx_ready && o_rx_valid) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_rx", 32'(o_rx_valid), 0);
        else chk("rnd_rx_data", 32'(o_rx_data), 32'(exp_q.pop_front()));
      end
      @(negedge clock_in);
    end
    i_tx_valid = 1'b0;
    i_rx_ready = 1'b1;
    for (int k = 0; k < 500 && exp_q.size() > 0; k++) begin
      if (o_rx_valid) chk("rnd_drain_data", 32'(o_rx_data), 32'(exp_q.pop_front()));
      @(negedge clock_in);
    end
    i_rx_ready = 1'b0;
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_load_unload_balance", 32'(n_unloads), 32'(n_loads));

    // Reset in the middle of SHIFT with three bytes queued
    key = 8'h0F;
    push(8'h70);
    push(8'h71);
    push(8'h72);
    i_tx_valid = 1'b0;
    repeat (3) @(negedge clock_in);
    chk("mid_busy_before_reset", 32'(o_busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_load",     32'(o_spi_load), 0);
    chk("mrst_unload",   32'(o_spi_unload), 0);
    chk("mrst_busy",     32'(o_busy), 0);
    chk("mrst_datain",   32'(o_spi_datain), 0);
    chk("mrst_tx_level", 32'(o_tx_level), 0);
    chk("mrst_rx_level", 32'(o_rx_level), 0);
    chk("mrst_tx_ready", 32'(o_tx_ready), 1);
    chk("mrst_rx_valid", 32'(o_rx_valid), 0);
    @(negedge clock_in);
    reset = 1'b0;
    n_unl0 = n_unloads;
    repeat (40) @(negedge clock_in);
    chk("post_rst_rx_level", 32'(o_rx_level), 0);
    chk("post_rst_rx_valid", 32'(o_rx_valid), 0);
    chk("post_rst_busy",     32'(o_busy), 0);
    chk("post_rst_unloads",  32'(n_unloads), 32'(n_unl0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
